// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed for a down-counter that starts at 'steps' and stops at zero.
  function automatic int cnt_bits(input int steps);
    return (steps < 1) ? 1 : $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle with valid/ready on both sides of the multiplier.
// Latency: n/a (wiring only).
// Backpressure: the producer holds operands until in_ready; the consumer stalls results with out_ready.
interface shift_add_multiplier_if #(
  parameter int WIDTH_A   = 8,
  parameter int WIDTH_B   = 8,
  parameter int WIDTH_OUT = WIDTH_A + WIDTH_B
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 signed_mode;
  logic [WIDTH_A-1:0]   multiplicand;
  logic [WIDTH_B-1:0]   multiplier;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_OUT-1:0] product;
  logic                 busy;

  modport master (
    output in_valid, signed_mode, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, signed_mode, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/shift_add_multiplier_sign_adjust.sv
// Conditional two's-complement negate; used both to take operand magnitudes and to sign the result.
// Latency: combinational.
// Backpressure: none.
module shift_add_multiplier_sign_adjust #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  // Negate when asked; the most-negative value maps onto itself, which reads back as 2^(W-1) unsigned.
  always_comb begin
    res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add multiplier, signed or unsigned per operation, with a zero-operand fast path.
// Latency: product valid WIDTH_B cycles after accept (1 cycle if either operand is zero).
// Backpressure: in_ready only in IDLE; the product is held in DONE until out_ready.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH_A   = 8,
  parameter int WIDTH_B   = 8,
  parameter int WIDTH_OUT = WIDTH_A + WIDTH_B
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  shift_add_multiplier_if.slave bus
);

  localparam int ACC_W = WIDTH_A + WIDTH_B;
  localparam int CNT_W = cnt_bits(WIDTH_B);
  localparam int EXT_W = (WIDTH_OUT > ACC_W) ? WIDTH_OUT : ACC_W;

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     mcand_q, mcand_d;
  logic [WIDTH_B-1:0]   mreg_q, mreg_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 sext_q, sext_d;
  logic                 zero_q, zero_d;
  logic [WIDTH_OUT-1:0] product_q, product_d;

  logic [WIDTH_A-1:0]   mag_a;
  logic [WIDTH_B-1:0]   mag_b;
  logic [ACC_W-1:0]     acc_sum;
  logic [ACC_W-1:0]     res_adj;
  logic [EXT_W-1:0]     res_ext;
  logic [WIDTH_OUT-1:0] fit_res;
  logic                 accept;
  logic                 run_last;

  assign accept   = bus.in_valid && (state_q == ST_IDLE);
  assign run_last = zero_q || (cnt_q == CNT_W'(1));
  assign acc_sum  = acc_q + (mreg_q[0] ? mcand_q : '0);

  shift_add_multiplier_sign_adjust #(.WIDTH(WIDTH_A)) u_abs_a (
    .val_i (bus.multiplicand),
    .neg_i (bus.signed_mode && bus.multiplicand[WIDTH_A-1]),
    .res_o (mag_a)
  );

  shift_add_multiplier_sign_adjust #(.WIDTH(WIDTH_B)) u_abs_b (
    .val_i (bus.multiplier),
    .neg_i (bus.signed_mode && bus.multiplier[WIDTH_B-1]),
    .res_o (mag_b)
  );

  // Result sign is applied to the sum that includes the final step's partial product.
  shift_add_multiplier_sign_adjust #(.WIDTH(ACC_W)) u_neg_res (
    .val_i (acc_sum),
    .neg_i (neg_q),
    .res_o (res_adj)
  );

  // Fit the full-width result to the output: sign-extend signed ops, zero-extend unsigned, or keep low bits.
  always_comb begin
    res_ext = EXT_W'(res_adj);
    if (sext_q) res_ext = EXT_W'($signed(res_adj));
  end
  assign fit_res = res_ext[WIDTH_OUT-1:0];

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept -> RUN, last step or zero operand -> DONE, handshake -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)        state_d = ST_RUN;
      ST_RUN:  if (run_last)      state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only, so no input-to-output path exists.
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    bus.busy      = (state_q != ST_IDLE);
  end
  assign bus.product = product_q;

  // Datapath next state: latch magnitudes at accept, one shift-add step per RUN cycle.
  always_comb begin
    mcand_d   = mcand_q;
    mreg_d    = mreg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    sext_d    = sext_q;
    zero_d    = zero_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mcand_d = ACC_W'(mag_a);
          mreg_d  = mag_b;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH_B);
          neg_d   = bus.signed_mode && (bus.multiplicand[WIDTH_A-1] ^ bus.multiplier[WIDTH_B-1]);
          sext_d  = bus.signed_mode;
          zero_d  = (bus.multiplicand == '0) || (bus.multiplier == '0);
        end
      end
      ST_RUN: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mreg_d  = mreg_q >> 1;
        cnt_d   = cnt_q - CNT_W'(1);
        // A zero operand leaves acc at zero, so the same path yields product 0 after one step.
        if (run_last) product_d = fit_res;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset drops any in-flight operation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mcand_q   <= '0;
      mreg_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      sext_q    <= 1'b0;
      zero_q    <= 1'b0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mreg_q    <= mreg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      sext_q    <= sext_d;
      zero_q    <= zero_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for the shift-add multiplier: 8x8->16 and 12x4->20 instances.
// Latency: checks WIDTH_B-cycle and zero-operand 1-cycle result timing.
// Backpressure: exercises out_ready stalls and ignored inputs while busy.
module tb_shift_add_multiplier;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_multiplier_if #(.WIDTH_A(8),  .WIDTH_B(8), .WIDTH_OUT(16)) if8 ();
  shift_add_multiplier_if #(.WIDTH_A(12), .WIDTH_B(4), .WIDTH_OUT(20)) if12 ();

  shift_add_multiplier #(.WIDTH_A(8),  .WIDTH_B(8), .WIDTH_OUT(16)) dut8  (.CLK(CLK), .RST_N(RST_N), .bus(if8));
  shift_add_multiplier #(.WIDTH_A(12), .WIDTH_B(4), .WIDTH_OUT(20)) dut12 (.CLK(CLK), .RST_N(RST_N), .bus(if12));

  typedef struct {
    int          which;
    bit          sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int which, input bit vld, input bit sm, input logic [31:0] a, input logic [31:0] b);
    if (which == 0) begin
      if8.in_valid = vld;  if8.signed_mode = sm;  if8.multiplicand = a[7:0];   if8.multiplier = b[7:0];
    end else begin
      if12.in_valid = vld; if12.signed_mode = sm; if12.multiplicand = a[11:0]; if12.multiplier = b[3:0];
    end
  endtask

  task automatic set_ordy(input int which, input bit r);
    if (which == 0) if8.out_ready = r;
    else            if12.out_ready = r;
  endtask

  function automatic logic get_ovld(input int which);
    return (which == 0) ? if8.out_valid : if12.out_valid;
  endfunction

  function automatic logic [31:0] get_prod(input int which);
    return (which == 0) ? 32'(if8.product) : 32'(if12.product);
  endfunction

  // Reference: interpret operands as plain integers, multiply, keep wo bits of the two's-complement result.
  function automatic logic [31:0] ref_mul(input bit sm, input logic [31:0] a, input logic [31:0] b,
                                          input int wa, input int wb, input int wo);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (sm) begin
      if (a[wa-1]) sa = sa - (longint'(1) << wa);
      if (b[wb-1]) sb = sb - (longint'(1) << wb);
    end
    p = sa * sb;
    return 32'(p & ((longint'(1) << wo) - 1));
  endfunction

  function automatic logic [31:0] rand_op(input int w);
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 32'(0);
    if (r == 1) return 32'(1) << (w - 1);
    return 32'($urandom_range(0, (1 << w) - 1));
  endfunction

  // Counts negedges from the one just after accept until out_valid; bounded.
  task automatic wait_out(input int which, output int lat);
    lat = 0;
    while (get_ovld(which) !== 1'b1 && lat < 40) begin
      lat++;
      @(negedge CLK);
    end
  endtask

  task automatic do_op(input int which, input bit sm, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] p, output int lat);
    @(negedge CLK);
    set_in(which, 1'b1, sm, a, b);
    set_ordy(which, hold == 0);
    @(negedge CLK);
    set_in(which, 1'b0, sm, a, b);
    wait_out(which, lat);
    repeat (hold) @(negedge CLK);
    p = get_prod(which);
    set_ordy(which, 1'b1);
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] p;
    int          lat;
    int          wa, wb, wo, hold;
    bit          sm;
    logic [31:0] a, b;

    RST_N = 1'b0;
    set_in(0, 1'b0, 1'b0, 0, 0);
    set_in(1, 1'b0, 1'b0, 0, 0);
    set_ordy(0, 1'b1);
    set_ordy(1, 1'b1);
    #12;
    check("rst_in_ready8",  32'(if8.in_ready),   1);
    check("rst_out_valid8", 32'(if8.out_valid),  0);
    check("rst_busy8",      32'(if8.busy),       0);
    check("rst_product8",   32'(if8.product),    0);
    check("rst_in_ready12", 32'(if12.in_ready),  1);
    check("rst_product12",  32'(if12.product),   0);
    @(negedge CLK);
    RST_N = 1'b1;

    // which, signed, A, B, expected product, expected latency
    vecs.push_back('{0, 1'b0, 32'd200,  32'd255,  32'h0000C738, 8});  // 51000
    vecs.push_back('{0, 1'b1, 32'h80,   32'h80,   32'h00004000, 8});  // -128*-128
    vecs.push_back('{0, 1'b1, 32'hFF,   32'h7F,   32'h0000FF81, 8});  // -1*127
    vecs.push_back('{0, 1'b0, 32'd0,    32'd173,  32'h00000000, 1});
    vecs.push_back('{0, 1'b0, 32'd91,   32'd0,    32'h00000000, 1});
    vecs.push_back('{0, 1'b1, 32'h00,   32'hFB,   32'h00000000, 1});  // 0*-5
    vecs.push_back('{0, 1'b1, 32'h7F,   32'h7F,   32'h00003F01, 8});  // 16129
    vecs.push_back('{0, 1'b1, 32'h80,   32'h7F,   32'h0000C080, 8});  // -16256
    vecs.push_back('{0, 1'b0, 32'hFF,   32'hFF,   32'h0000FE01, 8});  // 65025
    vecs.push_back('{1, 1'b1, 32'h800,  32'h7,    32'h000FC800, 4});  // -2048*7 = -14336
    vecs.push_back('{1, 1'b1, 32'h800,  32'h8,    32'h00004000, 4});  // -2048*-8
    vecs.push_back('{1, 1'b0, 32'hFFF,  32'hF,    32'h0000EFF1, 4});  // unsigned, zero-extended
    vecs.push_back('{1, 1'b1, 32'h005,  32'hF,    32'h000FFFFB, 4});  // 5*-1, sign-extended
    vecs.push_back('{1, 1'b0, 32'h000,  32'h9,    32'h00000000, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].which, vecs[i].sm, vecs[i].a, vecs[i].b, 0, p, lat);
      check($sformatf("vec%0d_product", i), p, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: 13*11 held while out_ready is low; a waiting 7*9 must not slip in early.
    @(negedge CLK);
    set_ordy(0, 1'b0);
    set_in(0, 1'b1, 1'b0, 13, 11);
    @(negedge CLK);
    set_in(0, 1'b1, 1'b0, 7, 9);
    wait_out(0, lat);
    check("bp_latency", 32'(lat), 8);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d_product", i), 32'(if8.product), 32'd143);
      check($sformatf("bp_hold%0d_in_ready", i), 32'(if8.in_ready), 0);
      check($sformatf("bp_hold%0d_out_valid", i), 32'(if8.out_valid), 1);
      @(negedge CLK);
    end
    set_ordy(0, 1'b1);
    @(negedge CLK);
    check("bp_after_hs_out_valid", 32'(if8.out_valid), 0);
    check("bp_after_hs_busy",      32'(if8.busy),      0);
    check("bp_after_hs_in_ready",  32'(if8.in_ready),  1);
    @(negedge CLK);
    set_in(0, 1'b0, 1'b0, 0, 0);
    check("bp_next_busy", 32'(if8.busy), 1);
    wait_out(0, lat);
    check("bp_next_latency", 32'(lat), 8);
    check("bp_next_product", 32'(if8.product), 32'd63);
    @(negedge CLK);

    // Asynchronous reset three steps into a run, between clock edges.
    @(negedge CLK);
    set_in(0, 1'b1, 1'b1, 32'hC8, 32'h37);
    @(negedge CLK);
    set_in(0, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge CLK);
    check("midrun_busy", 32'(if8.busy), 1);
    #2 RST_N = 1'b0;
    #1;
    check("arst_busy",      32'(if8.busy),      0);
    check("arst_in_ready",  32'(if8.in_ready),  1);
    check("arst_out_valid", 32'(if8.out_valid), 0);
    check("arst_product",   32'(if8.product),   0);
    @(negedge CLK);
    RST_N = 1'b1;
    do_op(0, 1'b0, 3, 5, 0, p, lat);
    check("post_rst_product", p, 32'd15);
    check("post_rst_latency", 32'(lat), 8);

    // Randomized sweep on both widths against the arithmetic reference.
    for (int w = 0; w < 2; w++) begin
      wa = (w == 0) ? 8 : 12;
      wb = (w == 0) ? 8 : 4;
      wo = (w == 0) ? 16 : 20;
      for (int n = 0; n < 1200; n++) begin
        sm   = 1'($urandom_range(0, 1));
        a    = rand_op(wa);
        b    = rand_op(wb);
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        do_op(w, sm, a, b, hold, p, lat);
        check($sformatf("rnd%0d_%0d_product", w, n), p, ref_mul(sm, a, b, wa, wb, wo));
        check($sformatf("rnd%0d_%0d_latency", w, n), 32'(lat), 32'((a == 0 || b == 0) ? 1 : wb));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
